// File: rtl/display_scheduler_if.sv
// Signal bundle between the display scheduler and its requesters/display driver.
// The scheduler attaches through the slave modport.
interface display_scheduler_if;
  logic [2:0]  req;
  logic [27:0] data_menu;
  logic [27:0] data_game;
  logic [27:0] data_result;
  logic        blink_en;
  logic [2:0]  grant;
  logic [6:0]  displayout;
  logic [3:0]  selector;
  logic        frame_done;

  modport master (
    output req, data_menu, data_game, data_result, blink_en,
    input  grant, displayout, selector, frame_done
  );

  modport slave (
    input  req, data_menu, data_game, data_result, blink_en,
    output grant, displayout, selector, frame_done
  );
endinterface

// File: rtl/display_scheduler.sv
// Four-digit multiplexed 7-segment scanner shared by three sources through a
// frame-granular fixed-priority arbiter with minimum hold, plus frame-based blink.
module display_scheduler #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned HOLD_FRAMES  = 4,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic             clk,
  input logic             rst,
  display_scheduler_if.slave bus
);
  localparam int unsigned CNT_W   = $clog2(CLK_DIV);
  localparam int unsigned HOLD_W  = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  digit_e             dig_q, dig_d;
  logic [2:0]         grant_q, grant_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               phase_q, phase_d;
  logic [3:0]         sel_q, sel_d;
  logic [6:0]         dout_q, dout_d;

  logic        tick;
  logic        boundary;
  logic        rearb;
  logic [2:0]  winner;
  logic [27:0] src;
  logic [6:0]  digit;

  // dig_q points at the digit to be latched on the next tick, so the first
  // tick after reset shows digit 0 and the wrap 3->0 marks the frame boundary.
  assign tick     = (cnt_q == CNT_W'(CLK_DIV - 1)) && !rst;
  assign boundary = tick && (dig_q == DIG3);

  always_comb begin
    winner = '0;
    if (bus.req[2])      winner = 3'b100;
    else if (bus.req[1]) winner = 3'b010;
    else if (bus.req[0]) winner = 3'b001;
  end

  always_comb begin
    case (grant_q)
      3'b100:  src = bus.data_result;
      3'b010:  src = bus.data_game;
      3'b001:  src = bus.data_menu;
      default: src = '1;
    endcase
  end

  always_comb begin
    case (dig_q)
      DIG0:    digit = src[6:0];
      DIG1:    digit = src[13:7];
      DIG2:    digit = src[20:14];
      default: digit = src[27:21];
    endcase
  end

  assign rearb = (grant_q == '0) || ((grant_q & bus.req) == '0) ||
                 (hold_q >= HOLD_W'(HOLD_FRAMES));

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    dig_d   = dig_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    if (tick) begin
      dig_d  = digit_e'(dig_q + 2'd1);
      sel_d  = ~(4'b0001 << dig_q);
      dout_d = (bus.blink_en && phase_q) ? '1 : digit;
    end
    if (boundary) begin
      if (rearb) grant_d = winner;
      // Re-granting the same owner keeps the hold counter saturated.
      if (grant_d != grant_q)                  hold_d = '0;
      else if (hold_q < HOLD_W'(HOLD_FRAMES))  hold_d = hold_q + HOLD_W'(1);
      if (bcnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dig_q   <= DIG0;
      grant_q <= '0;
      hold_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      sel_q   <= '1;
      dout_q  <= '1;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.selector   = sel_q;
  assign bus.displayout = dout_q;
  assign bus.frame_done = boundary;
endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, giving the clk cycles per digit scan tick (minimum 2).
REQ-002 SHALL have parameter HOLD_FRAMES, default 4, giving the minimum number of full frames a grant is kept while its request stays asserted (minimum 1).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, giving the number of frames per blink half-period (minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, 3 bits: display requests; bit0 menu, bit1 game, bit2 result.
REQ-007 SHALL have ports data_menu, data_game and data_result, input, 28 bits each: four 7-segment active-low patterns; digit i is bits [7i+6:7i].
REQ-008 SHALL have port blink_en, input, 1 bit: blank the display during odd blink phases.
REQ-009 SHALL have port grant, output, 3 bits: one-hot current owner, or 000 when there is no owner.
REQ-010 SHALL have port displayout, output, 7 bits: active-low segment drive.
REQ-011 SHALL have port selector, output, 4 bits: active-low digit enable, one-hot-low while scanning.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each 4-digit frame.

Function
REQ-013 SHALL run a prescaler counting 0..CLK_DIV-1 and wrapping to 0; tick SHALL be asserted for the one cycle in which the count equals CLK_DIV-1.
REQ-014 SHALL, on each tick, advance the digit index 0->1->2->3->0.
REQ-015 SHALL register selector and displayout on the tick cycle so that they update on the next clock edge, with selector bit of the new index low and the others high; this is one-cycle latency from tick.
REQ-016 SHALL take displayout from the granted source's digit field at the new index; with grant = 000, displayout SHALL be 7'b1111111 and selector SHALL keep scanning.
REQ-017 SHALL define the frame boundary as the tick on which the index wraps 3->0, and SHALL pulse frame_done for that same cycle.
REQ-018 SHALL change grant only at a frame boundary; the grant SHALL remain stable for the whole of a frame.
REQ-019 SHALL use fixed priority result > game > menu when choosing a new owner.
REQ-020 SHALL count frames since the last grant change in hold_cnt, saturating at HOLD_FRAMES.
REQ-021 SHALL, at a frame boundary, re-arbitrate when the owner's req bit is 0, or when hold_cnt >= HOLD_FRAMES, or when grant = 000; otherwise it SHALL keep the owner.
REQ-022 SHALL, on re-arbitration, grant the highest-priority asserted request; if no request is asserted, grant SHALL become 000.
REQ-023 SHALL clear hold_cnt only when grant actually changes value; re-granting the same owner SHALL leave hold_cnt saturated.
REQ-024 SHALL keep the grant until the frame boundary when the owner drops req mid-frame, showing the current data, with no early release.
REQ-025 SHALL NOT preempt a lower-priority owner inside its hold when a higher-priority request rises; the higher-priority requester SHALL wait for the hold to expire or the owner to release.
REQ-026 SHALL count frames in a blink counter and toggle phase every BLINK_FRAMES frames, with phase starting at 0.
REQ-027 SHALL, while blink_en = 1 and phase = 1, force displayout to 7'b1111111 without disturbing selector scanning; blink_en SHALL be sampled at each tick.
REQ-028 SHALL sample the data inputs at tick only; changes between ticks SHALL have no effect on the outputs.

Reset
REQ-029 SHALL, when rst = 1 at a clock edge, set the prescaler, digit index, hold_cnt, blink counter and phase to 0.
REQ-030 SHALL, when rst = 1 at a clock edge, set grant = 000, selector = 4'b1111, displayout = 7'b1111111 and frame_done = 0.
REQ-031 SHALL let rst override tick in the same cycle and SHALL abandon any frame in progress; the first tick after release SHALL occur CLK_DIV cycles after the release edge.

Verification (CLK_DIV=4, HOLD_FRAMES=2, BLINK_FRAMES=2)
REQ-032 SHALL cover scan: req=001, data_menu=28'h0A1B2C3 -> selector cycles 1110,1101,1011,0111 with one step per 4 clk cycles, displayout = data_menu[6:0], [13:7], [20:14], [27:21] in turn, and frame_done pulses every 16 cycles.
REQ-033 SHALL cover arbitration: req=011 from reset -> grant becomes 010 at the first frame boundary; drop req[1] mid-frame -> grant stays 010 until the boundary, then becomes 001.
REQ-034 SHALL cover hold: menu is granted; raise req[2] one frame after the grant -> grant stays 001 until hold_cnt = 2, then becomes 100 at that boundary.
REQ-035 SHALL cover blink: blink_en=1 with a granted source -> displayout is 7'h7F during frames 2-3, data during frames 4-5, and selector is unaffected throughout.
REQ-036 SHALL cover idle: req=000 -> grant=000, displayout=7'h7F, selector still scanning.
REQ-037 SHALL cover reset mid-frame: assert rst at index 2 -> next cycle selector=1111, grant=000; after release the first tick arrives 4 cycles later with selector=1110.
